btn_event_ctrl: RTL and testbench

Scheduler for the push-button debounce resource. It sits between the board's raw button pins and the CPU's MMIO input port. Each of `N_BTN` buttons gets its own debounce/click detector, and the resulting one-cycle click pulses are arbitrated round-robin into a small event FIFO. The CPU pops that FIFO one event at a time, so simultaneous clicks are never lost or merged across buttons.

---
 rtl/btn_pkg.sv | 20 ++
 rtl/btn_debounce.sv | 103 ++++++++++
 rtl/btn_event_ctrl.sv | 128 ++++++++++++
 tb/tb_btn_event_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button event controller.
package btn_pkg;

    // Debounce FSM states.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRESSING  = 2'd1,
        ST_HELD      = 2'd2,
        ST_RELEASING = 2'd3
    } db_state_e;

    // 20 ms of stable level at 100 MHz.
    localparam int COOL_CYC_DEFAULT = 2_000_000;

    // Round-robin successor of a button index.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Per-button synchronizer plus press/release debounce FSM.
// Emits a one-cycle click when a confirmed press is followed by a confirmed release.
//
//   state        | meaning
//   -------------+------------------------------------------------------------
//   IDLE         | button released and stable
//   PRESSING     | level is 1, counting cycles toward a confirmed press
//   HELD         | press confirmed, waiting for the level to drop
//   RELEASING    | level is 0, counting cycles toward a confirmed release
module btn_debounce
    import btn_pkg::*;
#(
    parameter int COOL_CYC = COOL_CYC_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic level_in,
    output logic click_out
);

    localparam logic [31:0] CNT_LAST = 32'(COOL_CYC - 1);

    logic [1:0]  sync_q;
    db_state_e   state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] cnt_inc;
    logic        level;
    logic        click_d;

    assign level     = sync_q[1];
    // Saturate rather than wrap so a stuck level can never alias a short count.
    assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;
    assign click_out = click_d;

    // Two-flop synchronizer for the asynchronous button pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], level_in};
        end
    end

    // Next-state and counter logic; click fires on the final release cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        click_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (level) begin
                    state_d = ST_PRESSING;
                    cnt_d   = '0;
                end
            end
            ST_PRESSING: begin
                if (!level) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_HELD: begin
                if (!level) begin
                    state_d = ST_RELEASING;
                    cnt_d   = '0;
                end
            end
            ST_RELEASING: begin
                if (level) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    click_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/btn_event_ctrl.sv
// Button event controller: per-button debouncers feed a pending register,
// a round-robin arbiter moves one pending click per cycle into a FWFT FIFO.
module btn_event_ctrl
    import btn_pkg::*;
#(
    parameter int N_BTN      = 5,
    parameter int COOL_CYC   = COOL_CYC_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_BTN-1:0]              btn_raw,
    input  logic                          rd_en,
    output logic                          ev_valid,
    output logic [$clog2(N_BTN)-1:0]      ev_code,
    output logic [$clog2(FIFO_DEPTH):0]   ev_count,
    output logic                          overflow,
    input  logic                          clr_ovf
);

    localparam int CW = $clog2(N_BTN);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0]   CNT_FULL  = FIFO_DEPTH[PW:0];
    localparam logic [CW-1:0] LAST_INIT = CW'(N_BTN - 1);

    logic [N_BTN-1:0] click;
    logic [N_BTN-1:0] pend_q, pend_d;
    logic [CW-1:0]    last_q, last_d;
    logic             ovf_q, ovf_d, ovf_event;

    logic [CW-1:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0]    wr_q, rd_q;
    logic [PW:0]      cnt_q, cnt_d;
    logic             full, push, pop;

    logic             grant_vld;
    logic [CW-1:0]    grant_idx;
    logic [N_BTN-1:0] grant_vec;
    int               idx;

    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        btn_debounce #(.COOL_CYC(COOL_CYC)) u_db (
            .clk       (clk),
            .rst       (rst),
            .level_in  (btn_raw[g]),
            .click_out (click[g])
        );
    end

    assign full = (cnt_q == CNT_FULL);
    assign pop  = rd_en && (cnt_q != '0);
    assign push = grant_vld;

    // Round-robin grant: first pending bit after last_grant, only when the FIFO has room.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        grant_vec = '0;
        idx       = int'(last_q);
        for (int k = 0; k < N_BTN; k++) begin
            idx = wrap_inc(idx, N_BTN);
            if (!grant_vld && !full && pend_q[idx]) begin
                grant_vld      = 1'b1;
                grant_idx      = idx[CW-1:0];
                grant_vec[idx] = 1'b1;
            end
        end
    end

    // Pending/overflow next state; a click landing on the granted bit simply re-arms it.
    always_comb begin
        pend_d    = (pend_q & ~grant_vec) | click;
        ovf_event = |(click & pend_q & ~grant_vec);
        last_d    = grant_vld ? grant_idx : last_q;
        if (ovf_event) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Pending register, arbiter pointer and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
            last_q <= LAST_INIT;
            ovf_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            last_q <= last_d;
            ovf_q  <= ovf_d;
        end
    end

    // Event FIFO storage and pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[wr_q] <= grant_idx;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop) begin
                rd_q <= rd_q + 1'b1;
            end
            cnt_q <= cnt_d;
        end
    end

    assign ev_valid = (cnt_q != '0);
    assign ev_code  = ev_valid ? mem_q[rd_q] : '0;
    assign ev_count = cnt_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Directed bench for btn_event_ctrl with COOL_CYC=4, N_BTN=5, FIFO_DEPTH=4.
module tb_btn_event_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] btn_raw;
    logic       rd_en;
    logic       clr_ovf;
    logic       ev_valid;
    logic [2:0] ev_code;
    logic [2:0] ev_count;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    btn_event_ctrl #(.N_BTN(5), .COOL_CYC(4), .FIFO_DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_raw),
        .rd_en    (rd_en),
        .ev_valid (ev_valid),
        .ev_code  (ev_code),
        .ev_count (ev_count),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [4:0] raw;
        logic       rd;
        logic       clr;
        int         cyc;
        logic       v;
        int         code;
        int         cnt;
        logic       ovf;
        int         hand;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic [4:0] raw, logic rd, logic clr, int cyc,
                                logic v, int code, int cnt, logic ovf);
        vec_t x;
        x.rst = r; x.raw = raw; x.rd = rd; x.clr = clr; x.cyc = cyc;
        x.v = v; x.code = code; x.cnt = cnt; x.ovf = ovf; x.hand = 0;
        return x;
    endfunction

    function automatic vec_t mkh(int h);
        vec_t x;
        x = mk(1'b0, 5'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b0);
        x.hand = h;
        return x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Clean click on button 2 with exact end-to-end latency.
    task automatic hand_clean_click();
        btn_raw = 5'b00100;
        repeat (10) tick();
        btn_raw = 5'b00000;
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk($sformatf("clean_early_cnt_%0d", k), int'(ev_count), 0);
        end
        tick();
        chk("clean_valid", int'(ev_valid), 1);
        chk("clean_code", int'(ev_code), 2);
        chk("clean_count", int'(ev_count), 1);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("clean_pop_valid", int'(ev_valid), 0);
        chk("clean_pop_count", int'(ev_count), 0);
    endtask

    // Button 1 held with FIFO full and pend[1] set: clear in the overflow cycle.
    task automatic hand_clear_contention();
        btn_raw = 5'b00000;
        repeat (6) tick();
        chk("contend_pre_ovf", int'(overflow), 0);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("contend_ovf", int'(overflow), 1);
        chk("contend_count", int'(ev_count), 4);
    endtask

    task automatic run_vec(int i, vec_t x);
        rst     = x.rst;
        btn_raw = x.raw;
        rd_en   = x.rd;
        clr_ovf = x.clr;
        tick();
        rst     = 1'b0;
        rd_en   = 1'b0;
        clr_ovf = 1'b0;
        repeat (x.cyc - 1) tick();
        chk($sformatf("v%0d_valid", i), int'(ev_valid), int'(x.v));
        chk($sformatf("v%0d_count", i), int'(ev_count), x.cnt);
        chk($sformatf("v%0d_ovf", i), int'(overflow), int'(x.ovf));
        if (x.v || x.rst) begin
            chk($sformatf("v%0d_code", i), int'(ev_code), x.code);
        end
    endtask

    initial begin
        //            rst  raw       rd   clr  cyc  v    code cnt ovf
        // reset state
        vecs.push_back(mk(1, 5'b00000, 0, 0, 1,  0, 0, 0, 0));
        vecs.push_back(mkh(1));
        // bounce on button 0, then a clean hold
        vecs.push_back(mk(0, 5'b00001, 0, 0, 2,  0, 0, 0, 0));
        vecs.push_back(mk(0, 5'b00000, 0, 0, 2,  0, 0, 0, 0));
        vecs.push_back(mk(0, 5'b00001, 0, 0, 2,  0, 0, 0, 0));
        vecs.push_back(mk(0, 5'b00000, 0, 0, 2,  0, 0, 0, 0));
        vecs.push_back(mk(0, 5'b00001, 0, 0, 8,  0, 0, 0, 0));
        vecs.push_back(mk(0, 5'b00000, 0, 0, 7,  0, 0, 0, 0));
        vecs.push_back(mk(0, 5'b00000, 0, 0, 1,  1, 0, 1, 0));
        vecs.push_back(mk(0, 5'b00000, 1, 0, 1,  0, 0, 0, 0));
        // simultaneous 1,3,4 from reset
        vecs.push_back(mk(1, 5'b00000, 0, 0, 1,  0, 0, 0, 0));
        vecs.push_back(mk(0, 5'b11010, 0, 0, 8,  0, 0, 0, 0));
        vecs.push_back(mk(0, 5'b00000, 0, 0, 7,  0, 0, 0, 0));
        vecs.push_back(mk(0, 5'b00000, 0, 0, 1,  1, 1, 1, 0));
        vecs.push_back(mk(0, 5'b00000, 0, 0, 1,  1, 1, 2, 0));
        vecs.push_back(mk(0, 5'b00000, 0, 0, 1,  1, 1, 3, 0));
        vecs.push_back(mk(0, 5'b00000, 0, 0, 1,  1, 1, 3, 0));
        vecs.push_back(mk(0, 5'b00000, 1, 0, 1,  1, 3, 2, 0));
        vecs.push_back(mk(0, 5'b00000, 1, 0, 1,  1, 4, 1, 0));
        vecs.push_back(mk(0, 5'b00000, 1, 0, 1,  0, 0, 0, 0));
        // second round 0 and 4 (last grant = 4)
        vecs.push_back(mk(0, 5'b10001, 0, 0, 8,  0, 0, 0, 0));
        vecs.push_back(mk(0, 5'b00000, 0, 0, 7,  0, 0, 0, 0));
        vecs.push_back(mk(0, 5'b00000, 0, 0, 1,  1, 0, 1, 0));
        vecs.push_back(mk(0, 5'b00000, 0, 0, 1,  1, 0, 2, 0));
        vecs.push_back(mk(0, 5'b00000, 1, 0, 1,  1, 4, 1, 0));
        vecs.push_back(mk(0, 5'b00000, 1, 0, 1,  0, 0, 0, 0));
        // full FIFO: 0,2,3,4 queued, then button 1 twice
        vecs.push_back(mk(0, 5'b11101, 0, 0, 8,  0, 0, 0, 0));
        vecs.push_back(mk(0, 5'b00000, 0, 0, 11, 1, 0, 4, 0));
        vecs.push_back(mk(0, 5'b00010, 0, 0, 8,  1, 0, 4, 0));
        vecs.push_back(mk(0, 5'b00000, 0, 0, 8,  1, 0, 4, 0));
        vecs.push_back(mk(0, 5'b00010, 0, 0, 8,  1, 0, 4, 0));
        vecs.push_back(mk(0, 5'b00000, 0, 0, 8,  1, 0, 4, 1));
        vecs.push_back(mk(0, 5'b00000, 1, 0, 1,  1, 2, 3, 1));
        vecs.push_back(mk(0, 5'b00000, 0, 0, 1,  1, 2, 4, 1));
        vecs.push_back(mk(0, 5'b00000, 1, 0, 1,  1, 3, 3, 1));
        vecs.push_back(mk(0, 5'b00000, 1, 0, 1,  1, 4, 2, 1));
        vecs.push_back(mk(0, 5'b00000, 1, 0, 1,  1, 1, 1, 1));
        vecs.push_back(mk(0, 5'b00000, 1, 0, 1,  0, 0, 0, 1));
        // clear alone, then set/clear contention
        vecs.push_back(mk(0, 5'b00000, 0, 1, 1,  0, 0, 0, 0));
        vecs.push_back(mk(0, 5'b11101, 0, 0, 8,  0, 0, 0, 0));
        vecs.push_back(mk(0, 5'b00000, 0, 0, 11, 1, 2, 4, 0));
        vecs.push_back(mk(0, 5'b00010, 0, 0, 8,  1, 2, 4, 0));
        vecs.push_back(mk(0, 5'b00000, 0, 0, 8,  1, 2, 4, 0));
        vecs.push_back(mk(0, 5'b00010, 0, 0, 8,  1, 2, 4, 0));
        vecs.push_back(mkh(2));
        vecs.push_back(mk(0, 5'b00000, 0, 1, 1,  1, 2, 4, 0));
        // reset while button 3 is releasing, 2 events queued
        vecs.push_back(mk(1, 5'b00000, 0, 0, 1,  0, 0, 0, 0));
        vecs.push_back(mk(0, 5'b00011, 0, 0, 8,  0, 0, 0, 0));
        vecs.push_back(mk(0, 5'b00000, 0, 0, 10, 1, 0, 2, 0));
        vecs.push_back(mk(0, 5'b01000, 0, 0, 8,  1, 0, 2, 0));
        vecs.push_back(mk(0, 5'b00000, 0, 0, 4,  1, 0, 2, 0));
        vecs.push_back(mk(1, 5'b00000, 0, 0, 1,  0, 0, 0, 0));
        vecs.push_back(mk(0, 5'b00000, 0, 0, 12, 0, 0, 0, 0));

        rst     = 1'b1;
        btn_raw = 5'b0;
        rd_en   = 1'b0;
        clr_ovf = 1'b0;
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].hand == 1) begin
                hand_clean_click();
            end else if (vecs[i].hand == 2) begin
                hand_clear_contention();
            end else begin
                run_vec(i, vecs[i]);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
